// File: rtl/aes_cmd_sequencer.sv
// Host-side command sequencer for the AES core: key/plaintext intake, core strobe protocol, ciphertext return.
// Optional AES_SEQ_CT_SKID_EN adds a one-entry ciphertext skid buffer so the next block can issue while the host holds ct.
module aes_cmd_sequencer #(
  parameter int KW      = 128,
  parameter int DW      = 128,
  parameter int TIMEOUT = 64
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          key_valid,
  input  logic [KW-1:0] key_in,
  output logic          key_ready,
  input  logic          pt_valid,
  input  logic [DW-1:0] pt_in,
  output logic          pt_ready,
  output logic          ct_valid,
  output logic [DW-1:0] ct_out,
  input  logic          ct_ready,
  output logic          EN,
  output logic          Krdy,
  output logic          Drdy,
  output logic [KW-1:0] Kin,
  output logic [DW-1:0] Din,
  input  logic          Kvld,
  input  logic          Dvld,
  input  logic [DW-1:0] Dout,
  output logic          err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_KEY_ISSUE  = 3'd1,
    S_KEY_WAIT   = 3'd2,
    S_DATA_ISSUE = 3'd3,
    S_DATA_WAIT  = 3'd4,
    S_RESULT     = 3'd5
  } state_t;

  state_t        state_r, state_nx_s;
  logic          key_loaded_r, key_loaded_nx_s;
  logic [TW-1:0] timer_r;
  logic          timer_hit_s, timeout_s;
  logic          key_acc_s, pt_acc_s, dvld_acc_s, pop_s;
  logic          key_block_s, pt_block_s;
  logic          en_r, krdy_r, drdy_r, err_r, ct_valid_r;
  logic          en_nx_s, krdy_nx_s, drdy_nx_s;
  logic [KW-1:0] kin_r;
  logic [DW-1:0] din_r, ct_out_r;

`ifdef AES_SEQ_CT_SKID_EN
  logic          sk_valid_r;
  logic [DW-1:0] sk_data_r;
  assign key_block_s = 1'b0;
  // A full skid entry stalls new plaintext unless it moves to the output this cycle.
  assign pt_block_s  = sk_valid_r & ~pop_s;
`else
  assign key_block_s = ct_valid_r;
  assign pt_block_s  = ct_valid_r;
`endif

  assign pop_s       = ct_valid_r & ct_ready;
  assign key_ready   = (state_r == S_IDLE) & ~key_block_s;
  assign pt_ready    = (state_r == S_IDLE) & key_loaded_r & ~key_valid & ~pt_block_s;
  assign key_acc_s   = key_valid & key_ready;
  assign pt_acc_s    = pt_valid & pt_ready;
  assign dvld_acc_s  = (state_r == S_DATA_WAIT) & Dvld;
  assign timer_hit_s = (timer_r == TW'(TIMEOUT - 1));

  assign EN          = en_r;
  assign Krdy        = krdy_r;
  assign Drdy        = drdy_r;
  assign Kin         = kin_r;
  assign Din         = din_r;
  assign ct_valid    = ct_valid_r;
  assign ct_out      = ct_out_r;
  assign err_timeout = err_r;

  // Next-state and key-loaded decode; a strobe on the final wait cycle beats the timeout.
  always_comb begin
    state_nx_s      = state_r;
    key_loaded_nx_s = key_loaded_r;
    timeout_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (key_acc_s) begin
          state_nx_s      = S_KEY_ISSUE;
          key_loaded_nx_s = 1'b0;
        end else if (pt_acc_s) begin
          state_nx_s = S_DATA_ISSUE;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_KEY_ISSUE:  state_nx_s = S_KEY_WAIT;
      S_KEY_WAIT: begin
        if (Kvld) begin
          state_nx_s      = S_IDLE;
          key_loaded_nx_s = 1'b1;
        end else if (timer_hit_s) begin
          state_nx_s      = S_IDLE;
          key_loaded_nx_s = 1'b0;
          timeout_s       = 1'b1;
        end else begin
          state_nx_s = S_KEY_WAIT;
        end
      end
      S_DATA_ISSUE: state_nx_s = S_DATA_WAIT;
      S_DATA_WAIT: begin
        if (Dvld) begin
`ifdef AES_SEQ_CT_SKID_EN
          state_nx_s = S_IDLE;
`else
          state_nx_s = S_RESULT;
`endif
        end else if (timer_hit_s) begin
          state_nx_s      = S_IDLE;
          key_loaded_nx_s = 1'b0;
          timeout_s       = 1'b1;
        end else begin
          state_nx_s = S_DATA_WAIT;
        end
      end
      S_RESULT: begin
        if (pop_s) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_RESULT;
        end
      end
      default: begin
        state_nx_s      = S_IDLE;
        key_loaded_nx_s = 1'b0;
      end
    endcase
  end

  // Core strobe decode from the upcoming state so the registered strobes align with ISSUE states.
  always_comb begin
    krdy_nx_s = 1'b0;
    drdy_nx_s = 1'b0;
    en_nx_s   = 1'b0;
    krdy_nx_s = (state_nx_s == S_KEY_ISSUE);
    drdy_nx_s = (state_nx_s == S_DATA_ISSUE);
    en_nx_s   = key_loaded_nx_s | (state_nx_s != S_IDLE);
  end

  // Control state, wait timer and core-side registers.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_r      <= S_IDLE;
      key_loaded_r <= 1'b0;
      timer_r      <= {TW{1'b0}};
      en_r         <= 1'b0;
      krdy_r       <= 1'b0;
      drdy_r       <= 1'b0;
      err_r        <= 1'b0;
      kin_r        <= {KW{1'b0}};
      din_r        <= {DW{1'b0}};
    end else begin
      state_r      <= state_nx_s;
      key_loaded_r <= key_loaded_nx_s;
      if ((state_r == S_KEY_WAIT) || (state_r == S_DATA_WAIT)) begin
        timer_r <= timer_r + TW'(1);
      end else begin
        timer_r <= {TW{1'b0}};
      end
      en_r   <= en_nx_s;
      krdy_r <= krdy_nx_s;
      drdy_r <= drdy_nx_s;
      err_r  <= timeout_s;
      if (key_acc_s) begin
        kin_r <= key_in;
      end
      if (pt_acc_s) begin
        din_r <= pt_in;
      end
    end
  end

  // Ciphertext return path; output register holds until the host takes it.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      ct_valid_r <= 1'b0;
      ct_out_r   <= {DW{1'b0}};
`ifdef AES_SEQ_CT_SKID_EN
      sk_valid_r <= 1'b0;
      sk_data_r  <= {DW{1'b0}};
`endif
    end else begin
`ifdef AES_SEQ_CT_SKID_EN
      if (dvld_acc_s) begin
        if (!ct_valid_r || pop_s) begin
          ct_valid_r <= 1'b1;
          ct_out_r   <= Dout;
        end else begin
          sk_valid_r <= 1'b1;
          sk_data_r  <= Dout;
        end
      end else if (pop_s) begin
        if (sk_valid_r) begin
          ct_out_r   <= sk_data_r;
          sk_valid_r <= 1'b0;
        end else begin
          ct_valid_r <= 1'b0;
        end
      end
`else
      if (dvld_acc_s) begin
        ct_valid_r <= 1'b1;
        ct_out_r   <= Dout;
      end else if (pop_s) begin
        ct_valid_r <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_aes_cmd_sequencer.sv
// Directed self-checking bench for aes_cmd_sequencer; the bench plays both host and AES core.
module tb_aes_cmd_sequencer;
  localparam int KW = 128;
  localparam int DW = 128;
  localparam int TIMEOUT = 64;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K3  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT3 = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] CT3 = 128'hcafef00dcafef00dcafef00dcafef00d;
  localparam logic [127:0] CT4 = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;

  logic          CLK = 1'b0;
  logic          RSTn, key_valid, pt_valid, ct_ready, Kvld, Dvld;
  logic [KW-1:0] key_in;
  logic [DW-1:0] pt_in, Dout;
  logic          key_ready, pt_ready, ct_valid, EN, Krdy, Drdy, err_timeout;
  logic [KW-1:0] Kin;
  logic [DW-1:0] Din, ct_out;

  int n_total = 0;
  int n_bad   = 0;
  int krdy_cnt = 0, drdy_cnt = 0, both_cnt = 0, en_low = 0;
  int k0, d0;
  bit en_watch = 1'b0;

  always #5 CLK = ~CLK;

  aes_cmd_sequencer #(.KW(KW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
    .pt_valid(pt_valid), .pt_in(pt_in), .pt_ready(pt_ready),
    .ct_valid(ct_valid), .ct_out(ct_out), .ct_ready(ct_ready),
    .EN(EN), .Krdy(Krdy), .Drdy(Drdy), .Kin(Kin), .Din(Din),
    .Kvld(Kvld), .Dvld(Dvld), .Dout(Dout), .err_timeout(err_timeout)
  );

  // Strobe monitor sampled mid-cycle.
  always @(negedge CLK) begin
    if (Krdy) krdy_cnt++;
    if (Drdy) drdy_cnt++;
    if (Krdy && Drdy) both_cnt++;
    if (en_watch && !EN) en_low++;
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_en"},   128'(EN), 128'(0));
    check_val({tag, "_krdy"}, 128'(Krdy), 128'(0));
    check_val({tag, "_drdy"}, 128'(Drdy), 128'(0));
    check_val({tag, "_ctv"},  128'(ct_valid), 128'(0));
    check_val({tag, "_err"},  128'(err_timeout), 128'(0));
    check_val({tag, "_kin"},  Kin, 128'(0));
    check_val({tag, "_din"},  Din, 128'(0));
    check_val({tag, "_ct"},   ct_out, 128'(0));
  endtask

  // Key handshake, then Kvld on wait cycle nwait.
  task automatic load_key(input logic [127:0] k, input int nwait);
    key_valid = 1'b1;
    key_in = k;
    #1;
    check_val("key_ready", 128'(key_ready), 128'(1));
    tick;
    key_valid = 1'b0;
    check_val("krdy_pulse", 128'(Krdy), 128'(1));
    check_val("kin", Kin, k);
    check_val("en_key", 128'(EN), 128'(1));
    check_val("no_drdy_key", 128'(Drdy), 128'(0));
    tick;
    check_val("krdy_single", 128'(Krdy), 128'(0));
    repeat (nwait - 1) tick;
    Kvld = 1'b1;
    tick;
    Kvld = 1'b0;
    check_val("kvld_err", 128'(err_timeout), 128'(0));
    check_val("kvld_key_ready", 128'(key_ready), 128'(1));
    check_val("kvld_en", 128'(EN), 128'(1));
    check_val("kvld_no_drdy", 128'(Drdy), 128'(0));
  endtask

  // Plaintext handshake at t, Dvld at t+lat, host stalls ct for 'stall' cycles.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] ct, input int lat, input int stall);
    pt_valid = 1'b1;
    pt_in = pt;
    #1;
    check_val("pt_ready", 128'(pt_ready), 128'(1));
    tick;
    pt_valid = 1'b0;
    check_val("drdy_pulse", 128'(Drdy), 128'(1));
    check_val("din", Din, pt);
    check_val("krdy_low", 128'(Krdy), 128'(0));
    tick;
    check_val("drdy_single", 128'(Drdy), 128'(0));
    repeat (lat - 2) tick;
    Dvld = 1'b1;
    Dout = ct;
    tick;
    Dvld = 1'b0;
    Dout = ~ct;
    check_val("ct_valid", 128'(ct_valid), 128'(1));
    check_val("ct_out", ct_out, ct);
    for (int i = 0; i < stall; i++) begin
      pt_valid = 1'b1;
      #1;
      check_val("stall_pt_ready", 128'(pt_ready), 128'(0));
      check_val("stall_key_ready", 128'(key_ready), 128'(0));
      tick;
      check_val("stall_ct_out", ct_out, ct);
      check_val("stall_ct_valid", 128'(ct_valid), 128'(1));
    end
    pt_valid = 1'b0;
    ct_ready = 1'b1;
    tick;
    ct_ready = 1'b0;
    check_val("ct_drop", 128'(ct_valid), 128'(0));
  endtask

  initial begin
    RSTn = 1'b0; key_valid = 1'b0; pt_valid = 1'b0; ct_ready = 1'b0;
    Kvld = 1'b0; Dvld = 1'b0; key_in = '0; pt_in = '0; Dout = '0;
    tick;
    tick;
    check_all_zero("rst");
    check_val("rst_key_ready", 128'(key_ready), 128'(1));
    check_val("rst_pt_ready", 128'(pt_ready), 128'(0));
    RSTn = 1'b1;

    // Stray Kvld in IDLE must not load a key.
    Kvld = 1'b1;
    tick;
    Kvld = 1'b0;
    pt_valid = 1'b1;
    #1;
    check_val("stray_kvld_pt_ready", 128'(pt_ready), 128'(0));
    check_val("stray_kvld_en", 128'(EN), 128'(0));
    pt_valid = 1'b0;

    load_key(K1, 5);
    run_block(PT1, CT1, 11, 5);

    // Stray Dvld in IDLE is ignored.
    Dvld = 1'b1;
    Dout = CT3;
    tick;
    Dvld = 1'b0;
    check_val("stray_dvld", 128'(ct_valid), 128'(0));

    // Three blocks on one key.
    k0 = krdy_cnt;
    d0 = drdy_cnt;
    en_watch = 1'b1;
    run_block(PT2, CT2, 3, 0);
    run_block(PT3, CT3, 5, 0);
    run_block(PT1, CT4, 2, 0);
    en_watch = 1'b0;
    check_val("b2b_drdy_cnt", 128'(drdy_cnt - d0), 128'(3));
    check_val("b2b_krdy_cnt", 128'(krdy_cnt - k0), 128'(0));
    check_val("b2b_coincide", 128'(both_cnt), 128'(0));
    check_val("b2b_en_low", 128'(en_low), 128'(0));

    // Simultaneous key and plaintext: key wins, data waits for the new Kvld.
    d0 = drdy_cnt;
    key_valid = 1'b1;
    key_in = K2;
    pt_valid = 1'b1;
    pt_in = PT2;
    #1;
    check_val("both_pt_ready", 128'(pt_ready), 128'(0));
    load_key(K2, 3);
    pt_valid = 1'b0;
    check_val("both_no_drdy", 128'(drdy_cnt - d0), 128'(0));
    run_block(PT2, CT2, 4, 0);

    // Kvld on the last permitted wait cycle wins over the timeout.
    load_key(K3, TIMEOUT);
    pt_valid = 1'b1;
    #1;
    check_val("edge_pt_ready", 128'(pt_ready), 128'(1));
    pt_valid = 1'b0;

`ifdef AES_SEQ_CT_SKID_EN
    pt_valid = 1'b1; pt_in = PT1;
    tick;
    pt_valid = 1'b0;
    tick;
    Dvld = 1'b1; Dout = CT1;
    tick;
    Dvld = 1'b0;
    check_val("sk_ct_a", ct_out, CT1);
    pt_valid = 1'b1; pt_in = PT2;
    #1;
    check_val("sk_pt_ready_b", 128'(pt_ready), 128'(1));
    tick;
    pt_valid = 1'b0;
    check_val("sk_drdy_b", 128'(Drdy), 128'(1));
    check_val("sk_ctv_b", 128'(ct_valid), 128'(1));
    tick;
    Dvld = 1'b1; Dout = CT2;
    tick;
    Dvld = 1'b0;
    check_val("sk_hold_a", ct_out, CT1);
    pt_valid = 1'b1; pt_in = PT3;
    #1;
    check_val("sk_stall_c", 128'(pt_ready), 128'(0));
    tick;
    check_val("sk_no_drdy_c", 128'(Drdy), 128'(0));
    ct_ready = 1'b1;
    #1;
    check_val("sk_drain_pt_ready", 128'(pt_ready), 128'(1));
    tick;
    pt_valid = 1'b0;
    ct_ready = 1'b0;
    check_val("sk_drdy_c", 128'(Drdy), 128'(1));
    check_val("sk_ct_b", ct_out, CT2);
    tick;
    Dvld = 1'b1; Dout = CT3;
    tick;
    Dvld = 1'b0;
    check_val("sk_hold_b", ct_out, CT2);
    ct_ready = 1'b1;
    tick;
    check_val("sk_ct_c", ct_out, CT3);
    tick;
    ct_ready = 1'b0;
    check_val("sk_empty", 128'(ct_valid), 128'(0));
`endif

    // Reset while waiting for Dvld.
    pt_valid = 1'b1;
    pt_in = PT3;
    tick;
    pt_valid = 1'b0;
    tick;
    RSTn = 1'b0;
    tick;
    RSTn = 1'b1;
    check_all_zero("midrst");
    Dvld = 1'b1;
    Dout = CT3;
    tick;
    Dvld = 1'b0;
    check_val("late_dvld_ctv", 128'(ct_valid), 128'(0));
    check_val("late_dvld_drdy", 128'(Drdy), 128'(0));
    pt_valid = 1'b1;
    #1;
    check_val("midrst_pt_ready", 128'(pt_ready), 128'(0));
    pt_valid = 1'b0;

    // Kvld withheld: abort after TIMEOUT wait cycles.
    key_valid = 1'b1;
    key_in = K1;
    tick;
    key_valid = 1'b0;
    check_val("to_krdy", 128'(Krdy), 128'(1));
    repeat (TIMEOUT) tick;
    check_val("to_err_early", 128'(err_timeout), 128'(0));
    check_val("to_en_early", 128'(EN), 128'(1));
    tick;
    check_val("to_err", 128'(err_timeout), 128'(1));
    check_val("to_en", 128'(EN), 128'(0));
    check_val("to_ctv", 128'(ct_valid), 128'(0));
    pt_valid = 1'b1;
    #1;
    check_val("to_pt_ready", 128'(pt_ready), 128'(0));
    check_val("to_key_ready", 128'(key_ready), 128'(1));
    tick;
    pt_valid = 1'b0;
    check_val("to_err_pulse", 128'(err_timeout), 128'(0));
    check_val("to_no_drdy", 128'(Drdy), 128'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_cmd_sequencer.md
Name: aes_cmd_sequencer

Overview:
Upstream sequencer for the AES core. It accepts a key and plaintext blocks from the host over valid/ready channels. It drives the core's EN/Krdy/Drdy/Kin/Din strobe interface, waits for Kvld/Dvld, and returns the ciphertext over a valid/ready channel. It guarantees the core-side protocol: single-cycle Krdy/Drdy pulses, never both high together, and EN held across a key/data sequence.

Parameters:
KW, 128, key width in bits
DW, 128, data block width in bits
TIMEOUT, 64, max cycles waited for Kvld/Dvld before abort (min 2)

Ports:
CLK  in  1  clock, all logic on posedge
RSTn  in  1  synchronous active-low reset
key_valid  in  1  host key offered
key_in  in  KW  host key
key_ready  out  1  sequencer accepts key this cycle
pt_valid  in  1  host plaintext offered
pt_in  in  DW  host plaintext
pt_ready  out  1  sequencer accepts plaintext this cycle
ct_valid  out  1  ciphertext available
ct_out  out  DW  ciphertext
ct_ready  in  1  host consumes ciphertext
EN  out  1  core enable
Krdy  out  1  core key strobe (1-cycle pulse)
Drdy  out  1  core data strobe (1-cycle pulse)
Kin  out  KW  key to core
Din  out  DW  data to core
Kvld  in  1  core key expansion done (pulse)
Dvld  in  1  core ciphertext valid (pulse)
Dout  in  DW  core ciphertext
err_timeout  out  1  1-cycle pulse on abort

Behaviour:
- Reset (RSTn=0 at posedge):
  - state=IDLE, key_loaded=0, timer=0.
  - EN, Krdy, Drdy, ct_valid and err_timeout are 0.
  - Kin, Din and ct_out are 0.
  - Reset mid-sequence aborts with no further strobes.
- All outputs are registered except key_ready/pt_ready, which decode from state.
- FSM states:
  - IDLE -> KEY_ISSUE on key_valid&key_ready.
  - IDLE -> DATA_ISSUE on pt_valid&pt_ready.
  - KEY_ISSUE -> KEY_WAIT.
  - KEY_WAIT -> IDLE on Kvld.
  - DATA_ISSUE -> DATA_WAIT.
  - DATA_WAIT -> RESULT on Dvld.
  - RESULT -> IDLE on ct_ready.
  - KEY_WAIT/DATA_WAIT -> IDLE on timeout.
- key_ready = IDLE & ~ct_valid.
- pt_ready = IDLE & key_loaded & ~key_valid & ~ct_valid. A simultaneous key and pt offer always takes the key first.
- Key handshake at cycle t:
  - Kin latched at t+1.
  - Krdy=1 during cycle t+1 only (KEY_ISSUE).
  - EN=1 from t+1.
- Kvld seen at cycle u: key_loaded=1, state IDLE at u+1. Kvld outside KEY_WAIT is ignored.
- Data handshake at cycle t:
  - Din latched and Drdy=1 during t+1 only.
  - Krdy stays 0.
- Dvld at cycle u:
  - ct_out <= Dout and ct_valid=1 at u+1.
  - ct_valid and ct_out hold stable until ct_ready; ct_valid drops the cycle after ct_valid&ct_ready.
  - Dvld outside DATA_WAIT is ignored.
- Key reuse: key_loaded stays 1; successive plaintexts reuse the key without another Krdy. A new key offer restarts KEY_ISSUE and clears key_loaded until Kvld.
- EN rules:
  - EN=1 whenever key_loaded or state is not IDLE.
  - EN=0 only after reset or abort.
  - Krdy and Drdy are never both 1.
  - Drdy is never asserted before the first Kvld.
- Timer:
  - Clears on entry to KEY_WAIT/DATA_WAIT and counts each wait cycle.
  - If it reaches TIMEOUT without the strobe: err_timeout pulses 1 cycle, key_loaded=0, EN=0, state=IDLE, no ct_valid.
  - A strobe arriving on the same cycle the timer hits TIMEOUT wins (no error).

Optional Feature:
AES_SEQ_CT_SKID_EN:
- Defined:
  - Adds a one-entry ciphertext buffer. DATA_WAIT -> IDLE directly on Dvld, loading the buffer.
  - key_ready and pt_ready ignore ct_valid, except that pt_ready=0 while the buffer is full and not being drained that cycle.
  - This allows the next Drdy while the host still holds the previous ct. RESULT state is unused.
- Undefined: behaviour exactly as above, with no new key or plaintext accepted while ct_valid=1.

Test Plan:
- Reset, key=000102..0F offered at cycle 2 -> Krdy single pulse at cycle 3 with Kin=key, EN=1; Kvld at cycle 8 -> key_ready=1 at cycle 9, no Drdy.
- Plaintext 00112233..FF after key loaded, core returns Dvld at t+11 with Dout=69C4E0D8..5A -> Drdy one pulse at t+1, ct_valid at t+12 with ct_out=69C4E0D8..5A; ct_ready held 0 for 5 cycles -> ct_out stable, pt_ready=0.
- Three back-to-back plaintexts, one key -> exactly one Krdy, three Drdy pulses, never coincident with Krdy, EN continuously 1.
- key_valid and pt_valid both 1 in IDLE with key loaded -> key accepted, pt_ready=0 that cycle, Krdy issued, Drdy only after the new Kvld.
- Kvld withheld, TIMEOUT=64 -> err_timeout pulse at cycle 64 of KEY_WAIT, EN=0, a subsequent pt_valid is not accepted (pt_ready=0); RSTn=0 during DATA_WAIT -> all outputs 0 next cycle, late Dvld ignored.
- With AES_SEQ_CT_SKID_EN, ct_ready=0 -> second Drdy issued while ct_valid=1; third plaintext stalls (pt_ready=0) until ct_ready.
